// File: rtl/ctrl_74hc165.sv
// Scan controller for a chain of 74HC165 shift registers: pulses PL, clocks the
// chain MSB-first through a synchronised Q7 and presents the word with a valid strobe.
module ctrl_74hc165 #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4,
   parameter int AUTO    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_q7,
   output logic             o_pl,
   output logic             o_cp,
   output logic             o_busy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_LOW  = 3'd2,
      S_HIGH = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             pl_q, pl_d;
   logic             cp_q, cp_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             sync1_q, sync2_q;
   logic             start_s;
   logic             phase_end_s;

   assign start_s     = (AUTO != 0) || i_start;
   assign phase_end_s = (phase_q == PH_LAST);

   // Two-flop synchroniser for the asynchronous Q7 pin
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_q7;
         sync2_q <= sync1_q;
      end
   end

   // Next-state, counters, shift path and pin values
   always_comb begin
      state_d = state_q;
      phase_d = phase_q + PW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            phase_d = '0;
            if (start_s) begin
               state_d = S_LOAD;
               bit_d   = '0;
               shift_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (phase_end_s) begin
               state_d = S_LOW;
               phase_d = '0;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOW: begin
            if (phase_end_s) begin
               phase_d = '0;
               shift_d = {shift_q[WIDTH-2:0], sync2_q};
               bit_d   = bit_q + BW'(1);
               if ((bit_q + BW'(1)) == BIT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_HIGH;
               end
            end else begin
               state_d = S_LOW;
            end
         end
         S_HIGH: begin
            if (phase_end_s) begin
               state_d = S_LOW;
               phase_d = '0;
            end else begin
               state_d = S_HIGH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase

      // Pins are decoded from the next state so they switch with the state register
      if (state_d == S_DONE) begin
         data_d = shift_d;
      end else begin
         data_d = data_q;
      end
      pl_d    = (state_d != S_LOAD);
      cp_d    = (state_d == S_HIGH);
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_DONE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         pl_q    <= 1'b1;
         cp_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         pl_q    <= pl_d;
         cp_q    <= cp_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign o_pl    = pl_q;
   assign o_cp    = cp_q;
   assign o_busy  = busy_q;
   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_ctrl_74hc165.sv
// Bench for ctrl_74hc165: three instances (8/4, 16/2 chained, 8/4 AUTO) driven by
// 74HC165 chip models and checked against a timeline model plus literal expectations.
module tb_ctrl_74hc165;

   localparam int WV[3] = '{8, 16, 8};
   localparam int DV[3] = '{4, 2, 4};
   localparam int AV[3] = '{0, 0, 1};

   logic        clk = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [2:0]  rst_v = 3'b111;
   logic [2:0]  start_v = 3'b000;
   logic [2:0]  pl_v, cp_v, busy_v, valid_v;
   wire  [2:0]  q7_v;
   logic [7:0]  data8, data_a;
   logic [15:0] data16;
   logic [15:0] pre_v[3];
   logic        tog = 1'b0;
   logic        tog_en = 1'b1;

   logic [7:0]  c8 = 8'h00, c_last = 8'h00, c_first = 8'h00, c_a = 8'h00;

   int          ss[3] = '{-1, -1, -1};
   logic [15:0] ed[3] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] cap[3] = '{16'h0, 16'h0, 16'h0};
   logic        known[3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ctrl_74hc165 #(.WIDTH(8), .CLK_DIV(4), .AUTO(0)) u_d8 (
      .clk(clk), .rst(rst_v[0]), .i_start(start_v[0]), .i_q7(q7_v[0]),
      .o_pl(pl_v[0]), .o_cp(cp_v[0]), .o_busy(busy_v[0]), .o_valid(valid_v[0]), .o_data(data8));
   ctrl_74hc165 #(.WIDTH(16), .CLK_DIV(2), .AUTO(0)) u_d16 (
      .clk(clk), .rst(rst_v[1]), .i_start(start_v[1]), .i_q7(q7_v[1]),
      .o_pl(pl_v[1]), .o_cp(cp_v[1]), .o_busy(busy_v[1]), .o_valid(valid_v[1]), .o_data(data16));
   ctrl_74hc165 #(.WIDTH(8), .CLK_DIV(4), .AUTO(1)) u_da (
      .clk(clk), .rst(rst_v[2]), .i_start(start_v[2]), .i_q7(q7_v[2]),
      .o_pl(pl_v[2]), .o_cp(cp_v[2]), .o_busy(busy_v[2]), .o_valid(valid_v[2]), .o_data(data_a));

   // 74HC165 chip models: load while PL low, shift towards Q7 on CP rising
   always @(negedge pl_v[0] or posedge cp_v[0])
      if (!pl_v[0]) c8 <= pre_v[0][7:0]; else c8 <= {c8[6:0], 1'b0};
   always @(negedge pl_v[1] or posedge cp_v[1])
      if (!pl_v[1]) begin
         c_last  <= pre_v[1][15:8];
         c_first <= pre_v[1][7:0];
      end else begin
         c_last  <= {c_last[6:0], c_first[7]};
         c_first <= {c_first[6:0], 1'b0};
      end
   always @(negedge pl_v[2] or posedge cp_v[2])
      if (!pl_v[2]) c_a <= pre_v[2][7:0]; else c_a <= {c_a[6:0], 1'b0};

   assign q7_v[0] = tog_en ? tog : c8[7];
   assign q7_v[1] = tog_en ? ~tog : c_last[7];
   assign q7_v[2] = tog_en ? tog : c_a[7];

   function automatic logic [15:0] getd(input int k);
      case (k)
         0:       getd = {8'h00, data8};
         1:       getd = data16;
         default: getd = {8'h00, data_a};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Timeline model: cycle t after the start cycle decides every pin value
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int t, p, last;
         logic act;
         last = 2 * WV[k] * DV[k] + 1;
         t    = (ss[k] >= 0) ? (cyc - ss[k]) : 0;
         act  = (ss[k] >= 0) && (t >= 1) && (t <= last);
         p    = (t - 1) / DV[k];
         if (known[k]) begin
            if (act && t == DV[k]) cap[k] = pre_v[k] & (16'hFFFF >> (16 - WV[k]));
            if (act && t == last) ed[k] = cap[k];
            check($sformatf("pl[%0d]", k), {31'd0, pl_v[k]}, {31'd0, !(act && t <= DV[k])});
            check($sformatf("cp[%0d]", k), {31'd0, cp_v[k]},
                  {31'd0, act && t > DV[k] && t < last && (p % 2 == 0)});
            check($sformatf("busy[%0d]", k), {31'd0, busy_v[k]}, {31'd0, act});
            check($sformatf("valid[%0d]", k), {31'd0, valid_v[k]}, {31'd0, act && t == last});
            check($sformatf("data[%0d]", k), {16'd0, getd(k)}, {16'd0, ed[k]});
         end
         if (rst_v[k]) begin
            known[k] = 1'b1;
            ss[k]    = -1;
            ed[k]    = 16'h0;
         end else if (known[k] && !act && (start_v[k] || AV[k] != 0)) begin
            ss[k] = cyc;
         end
      end
   end

   task automatic watch(input int k, input int hold, input int want,
                        output int lat1, output int lat2, output int edges,
                        output int pl_low, output int busy_n, output int nval,
                        output logic [15:0] d1, output logic [15:0] d2);
      int sc, i;
      logic cp_prev;
      lat1 = -1; lat2 = -1; edges = 0; pl_low = 0; busy_n = 0; nval = 0;
      d1 = 16'h0; d2 = 16'h0; i = 0;
      @(posedge clk); #1;
      start_v[k] = 1'b1;
      sc = cyc;
      cp_prev = cp_v[k];
      while (nval < want && i < 400) begin
         @(posedge clk); #1;
         if (cyc - sc >= hold) start_v[k] = 1'b0;
         @(negedge clk);
         if (!pl_v[k]) pl_low++;
         if (busy_v[k]) busy_n++;
         if (cp_v[k] && !cp_prev) edges++;
         cp_prev = cp_v[k];
         if (valid_v[k]) begin
            nval++;
            if (nval == 1) begin
               lat1 = cyc - sc;
               d1 = getd(k);
               if (k == 2) pre_v[2] = 16'h00F0;
            end else begin
               lat2 = cyc - sc;
               d2 = getd(k);
            end
         end
         i++;
      end
      @(posedge clk); #1;
      start_v[k] = 1'b0;
   endtask

   initial begin
      int lat1, lat2, edges, pl_low, busy_n, nval, sc, nv;
      logic [15:0] d1, d2;
      logic cp_prev;
      pre_v[0] = 16'h00A5;
      pre_v[1] = 16'h1234;
      pre_v[2] = 16'h000F;

      // Reset with Q7 toggling
      edges = 0;
      cp_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tog = ~tog;
         @(negedge clk);
         if (i > 0 && cp_v != 3'b000 && cp_prev == 1'b0) edges++;
         cp_prev = |cp_v;
      end
      check("rst_pl", {29'd0, pl_v}, 32'h7);
      check("rst_cp", {29'd0, cp_v}, 32'h0);
      check("rst_busy", {29'd0, busy_v}, 32'h0);
      check("rst_valid", {29'd0, valid_v}, 32'h0);
      check("rst_data", {8'd0, data16, data8}, 32'h0);
      check("rst_cp_edges", edges, 32'd0);
      @(posedge clk); #1;
      rst_v  = 3'b000;
      tog_en = 1'b0;
      repeat (3) @(posedge clk);

      // Single 8-bit scan of 8'hA5
      watch(0, 1, 1, lat1, lat2, edges, pl_low, busy_n, nval, d1, d2);
      check("s8_nvalid", nval, 32'd1);
      check("s8_latency", lat1, 32'd65);
      check("s8_data", {16'd0, d1}, 32'h00A5);
      check("s8_edges", edges, 32'd7);
      check("s8_pl_low", pl_low, 32'd4);
      check("s8_busy", busy_n, 32'd65);
      repeat (3) @(posedge clk);

      // Two chained chips holding 16'h1234
      watch(1, 1, 1, lat1, lat2, edges, pl_low, busy_n, nval, d1, d2);
      check("s16_nvalid", nval, 32'd1);
      check("s16_latency", lat1, 32'd65);
      check("s16_data", {16'd0, d1}, 32'h1234);
      check("s16_edges", edges, 32'd15);
      check("s16_pl_low", pl_low, 32'd2);
      check("s16_busy", busy_n, 32'd65);
      repeat (3) @(posedge clk);

      // Start held high through cycle 80
      watch(0, 81, 2, lat1, lat2, edges, pl_low, busy_n, nval, d1, d2);
      check("busy_nvalid", nval, 32'd2);
      check("busy_lat1", lat1, 32'd65);
      check("busy_lat2", lat2, 32'd131);
      check("busy_edges", edges, 32'd14);
      check("busy_pl_low", pl_low, 32'd8);
      check("busy_busy", busy_n, 32'd130);
      repeat (3) @(posedge clk);

      // Reset in cycle 30 of a scan
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      sc = cyc;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      while (cyc - sc < 30) begin
         @(posedge clk); #1;
      end
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      @(negedge clk);
      check("mid_cycle", cyc - sc, 32'd31);
      check("mid_pl", {31'd0, pl_v[0]}, 32'd1);
      check("mid_cp", {31'd0, cp_v[0]}, 32'd0);
      check("mid_busy", {31'd0, busy_v[0]}, 32'd0);
      check("mid_valid", {31'd0, valid_v[0]}, 32'd0);
      check("mid_data", {24'd0, data8}, 32'd0);
      nv = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (valid_v[0]) nv++;
      end
      check("mid_no_valid", nv, 32'd0);
      pre_v[0] = 16'h003C;
      watch(0, 1, 1, lat1, lat2, edges, pl_low, busy_n, nval, d1, d2);
      check("mid_rescan_latency", lat1, 32'd65);
      check("mid_rescan_data", {16'd0, d1}, 32'h003C);

      // AUTO rescans, start ignored, value changes between scans
      watch(2, 40, 2, lat1, lat2, edges, pl_low, busy_n, nval, d1, d2);
      check("auto_nvalid", nval, 32'd2);
      check("auto_period", lat2 - lat1, 32'd66);
      check("auto_data1", {16'd0, d1}, 32'h000F);
      check("auto_data2", {16'd0, d2}, 32'h00F0);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
